// File: rtl/phase_sequencer.sv
// Run/step controller for the 5-phase multi-cycle datapath: debounces the
// run/stop and step buttons, sequences phases 1..5, and counts retired instructions.
module phase_sequencer #(
   parameter int unsigned DB_COUNT = 50000,
   parameter int unsigned DB_W     = 16,
   parameter int unsigned RET_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             exec_btn,
   input  logic             step_btn,
   input  logic             halt,
   output logic [2:0]       phase,
   output logic             pc_e,
   output logic             running,
   output logic             halted,
   output logic [RET_W-1:0] retired
);

   localparam int unsigned N_BTN = 2;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_STEP   = 2'd2,
      S_HALTED = 2'd3
   } state_t;

   // Button index 0 = exec (run/stop), 1 = step; all levels active-low
   logic [N_BTN-1:0] w_raw;
   logic [N_BTN-1:0] r_sync1;
   logic [N_BTN-1:0] r_sync2;
   logic [N_BTN-1:0] r_db;
   logic [N_BTN-1:0] r_press;
   logic [DB_W-1:0]  r_cnt [N_BTN];

   state_t           r_state;
   state_t           w_nxt_state;
   logic [2:0]       r_phase;
   logic [2:0]       w_nxt_phase;
   logic             r_stop_req;
   logic             w_nxt_stop;
   logic             r_pc_e;
   logic             r_running;
   logic             r_halted;
   logic [RET_W-1:0] r_retired;
   logic [RET_W-1:0] w_nxt_retired;
   logic             w_exec;
   logic             w_step;

   assign w_raw  = {step_btn, exec_btn};
   assign w_exec = r_press[0];
   assign w_step = r_press[1];

   // Synchronize, debounce, and emit a one-cycle pulse on each accepted press
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1 <= '1;
         r_sync2 <= '1;
         r_db    <= '1;
         r_press <= '0;
         for (int i = 0; i < int'(N_BTN); i++) r_cnt[i] <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
         r_press <= '0;
         for (int i = 0; i < int'(N_BTN); i++) begin
            if (r_sync2[i] == r_db[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == DB_W'(DB_COUNT)) begin
               r_db[i]    <= r_sync2[i];
               r_cnt[i]   <= '0;
               r_press[i] <= ~r_sync2[i];
            end else begin
               r_cnt[i] <= r_cnt[i] + DB_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_phase    <= 3'd0;
         r_stop_req <= 1'b0;
         r_pc_e     <= 1'b0;
         r_running  <= 1'b0;
         r_halted   <= 1'b0;
         r_retired  <= '0;
      end else begin
         r_state    <= w_nxt_state;
         r_phase    <= w_nxt_phase;
         r_stop_req <= w_nxt_stop;
         r_pc_e     <= (w_nxt_phase == 3'd5);
         r_running  <= (w_nxt_phase != 3'd0);
         r_halted   <= (w_nxt_state == S_HALTED);
         r_retired  <= w_nxt_retired;
      end
   end

   always_comb begin
      w_nxt_state   = r_state;
      w_nxt_phase   = r_phase;
      w_nxt_stop    = r_stop_req;
      w_nxt_retired = r_retired;
      case (r_state)
         S_IDLE: begin
            w_nxt_phase = 3'd0;
            w_nxt_stop  = 1'b0;
            if (w_exec) begin
               w_nxt_state = S_RUN;
               w_nxt_phase = 3'd1;
            end else if (w_step) begin
               w_nxt_state = S_STEP;
               w_nxt_phase = 3'd1;
            end
         end
         S_RUN: begin
            if (w_exec) w_nxt_stop = 1'b1;
            case (r_phase)
               3'd1, 3'd2, 3'd3, 3'd4: w_nxt_phase = r_phase + 3'd1;
               3'd5: begin
                  w_nxt_retired = r_retired + RET_W'(1);
                  // Halt outranks a pending stop; either ends the run after this instruction
                  if (halt) begin
                     w_nxt_state = S_HALTED;
                     w_nxt_phase = 3'd0;
                     w_nxt_stop  = 1'b0;
                  end else if (r_stop_req) begin
                     w_nxt_state = S_IDLE;
                     w_nxt_phase = 3'd0;
                     w_nxt_stop  = 1'b0;
                  end else begin
                     w_nxt_phase = 3'd1;
                  end
               end
               default: begin
                  w_nxt_state = S_IDLE;
                  w_nxt_phase = 3'd0;
                  w_nxt_stop  = 1'b0;
               end
            endcase
         end
         S_STEP: begin
            case (r_phase)
               3'd1, 3'd2, 3'd3, 3'd4: w_nxt_phase = r_phase + 3'd1;
               3'd5: begin
                  w_nxt_retired = r_retired + RET_W'(1);
                  w_nxt_state   = halt ? S_HALTED : S_IDLE;
                  w_nxt_phase   = 3'd0;
               end
               default: begin
                  w_nxt_state = S_IDLE;
                  w_nxt_phase = 3'd0;
               end
            endcase
         end
         S_HALTED: begin
            w_nxt_phase = 3'd0;
            w_nxt_stop  = 1'b0;
         end
         default: begin
            w_nxt_state = S_IDLE;
            w_nxt_phase = 3'd0;
            w_nxt_stop  = 1'b0;
         end
      endcase
   end

   assign phase   = r_phase;
   assign pc_e    = r_pc_e;
   assign running = r_running;
   assign halted  = r_halted;
   assign retired = r_retired;

endmodule
